// File: rtl/vend_pkg.sv
// Shared definitions for the change dispenser: state codes, coin values
// and the timer width helper.
package vend_pkg;

    // State codes. Code 7 is unused; the FSM recovers from it to IDLE.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DECIDE  = 3'd1,
        PULSE_D = 3'd2,
        PULSE_N = 3'd3,
        GAP     = 3'd4,
        DONE    = 3'd5,
        FAULT   = 3'd6
    } state_e;

    // Coin values in nickel units.
    localparam int NICKEL_U = 1;
    localparam int DIME_U   = 2;

    // Width of a down-counter that must hold max(p, g) - 1.
    // The extra bit gives headroom for exact powers of two.
    function automatic int tmr_w(input int p, input int g);
        return $clog2((p > g) ? p : g) + 1;
    endfunction

endpackage

// File: rtl/change_dispenser_timer.sv
// Down-counter shared by the PULSE and GAP states. Loaded on state entry
// with (hold cycles - 1); it reports expiry once the count reaches zero.
module cycle_timer #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load takes priority; otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: takes an amount in nickels over a Ready/Req handshake
// and drives timed dime/nickel eject pulses, dimes first, nickels as the
// fallback. Ends in DONE on full payout, or FAULT when the rest is unpayable.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W     = 4,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic [AMT_W-1:0] amount_i,
    input  logic             dime_empty_i,
    input  logic             nickel_empty_i,
    output logic             ready_o,
    output logic             eject_d_o,
    output logic             eject_n_o,
    output logic             done_o,
    output logic             fault_o,
    output logic [AMT_W-1:0] remaining_o,
    output logic [2:0]       state_o
);

    localparam int TW = tmr_w(PULSE_CYC, GAP_CYC);
    localparam logic [TW-1:0]    PULSE_LD = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0]    GAP_LD   = TW'(GAP_CYC - 1);
    localparam logic [AMT_W-1:0] DIME_A   = AMT_W'(DIME_U);
    localparam logic [AMT_W-1:0] NICKEL_A = AMT_W'(NICKEL_U);

    state_e           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             fault_q, fault_d;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_expired;

    cycle_timer #(.W(TW)) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    // Next-state logic. Each pulse is debited on its last cycle, so the
    // DECIDE guards keep Remaining from ever underflowing.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        fault_d  = fault_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    rem_d   = amount_i;
                    fault_d = 1'b0;
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                if (rem_q == '0) begin
                    state_d = DONE;
                end else if (rem_q >= DIME_A && !dime_empty_i) begin
                    state_d  = PULSE_D;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end else if (rem_q >= NICKEL_A && !nickel_empty_i) begin
                    state_d  = PULSE_N;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end else begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end
            end
            PULSE_D, PULSE_N: begin
                if (tmr_expired) begin
                    rem_d    = rem_q - ((state_q == PULSE_D) ? DIME_A : NICKEL_A);
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                end
            end
            GAP: begin
                if (tmr_expired) begin
                    state_d = DECIDE;
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, remaining-amount and sticky fault registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rem_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            fault_q <= fault_d;
        end
    end

    // Moore outputs, decoded from registered state only.
    assign ready_o     = (state_q == IDLE);
    assign eject_d_o   = (state_q == PULSE_D);
    assign eject_n_o   = (state_q == PULSE_N);
    assign done_o      = (state_q == DONE);
    assign fault_o     = fault_q;
    assign remaining_o = rem_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus random transactions.
// The driver pushes the expected outcome of each request into a queue and
// an independent monitor checks every DONE/FAULT event against it.
module tb_change_dispenser;

    localparam int AMT_W    = 4;
    localparam int P        = 2;
    localparam int G        = 3;
    localparam int COIN_CYC = 1 + P + G;
    localparam int NO_SW    = 99;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req = 1'b0;
    logic [AMT_W-1:0] amount = '0;
    logic             dime_empty = 1'b0;
    logic             nickel_empty = 1'b0;
    logic             ready_o, eject_d_o, eject_n_o, done_o, fault_o;
    logic [AMT_W-1:0] remaining_o;
    logic [2:0]       state_o;

    always #5 clk = ~clk;

    change_dispenser #(.AMT_W(AMT_W), .PULSE_CYC(P), .GAP_CYC(G)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .amount_i       (amount),
        .dime_empty_i   (dime_empty),
        .nickel_empty_i (nickel_empty),
        .ready_o        (ready_o),
        .eject_d_o      (eject_d_o),
        .eject_n_o      (eject_n_o),
        .done_o         (done_o),
        .fault_o        (fault_o),
        .remaining_o    (remaining_o),
        .state_o        (state_o)
    );

    typedef struct {
        int fault;
        int dimes;
        int nickels;
        int rem;
        int dur;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Payout model: greedy dimes, nickels as fallback, never overpay.
    // Hopper flags switch from (de0,ne0) to (de1,ne1) at decision index k.
    // Outcome appears 2 cycles after accept plus one coin period per coin.
    function automatic exp_t model(input int amt, input bit de0, input bit ne0,
                                   input bit de1, input bit ne1, input int k);
        exp_t e;
        int   owed = amt;
        int   coins = 0;
        bit   de, ne;
        e.dimes = 0; e.nickels = 0; e.fault = 0;
        while (owed > 0) begin
            de = (coins >= k) ? de1 : de0;
            ne = (coins >= k) ? ne1 : ne0;
            if (owed >= 2 && !de) begin
                e.dimes++; owed -= 2;
            end else if (!ne) begin
                e.nickels++; owed -= 1;
            end else begin
                e.fault = 1;
                break;
            end
            coins++;
        end
        e.rem = owed;
        e.dur = 2 + coins * COIN_CYC;
        return e;
    endfunction

    // Monitor: samples 1ns after each rising edge, tracks pulses and checks
    // every DONE/FAULT against the head of the scoreboard.
    bit       mon_en = 1'b0;
    int       cyc = 0, dimes = 0, nickels = 0, run_d = 0, run_n = 0, n_acc = 0;
    logic [2:0] prev_s = 3'd0;
    logic     prev_d = 1'b0, prev_n = 1'b0;
    exp_t     me;

    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            check("eject_exclusive", int'(eject_d_o & eject_n_o), 0);
            check("ready_with_eject", int'(ready_o & (eject_d_o | eject_n_o)), 0);
            if (prev_s == 3'd0 && state_o == 3'd1) begin
                n_acc++; cyc = 1; dimes = 0; nickels = 0;
            end else begin
                cyc++;
            end
            if (eject_d_o && !prev_d) dimes++;
            if (eject_n_o && !prev_n) nickels++;
            if (eject_d_o) run_d++;
            else if (prev_d) begin check("pulse_d_len", run_d, P); run_d = 0; end
            if (eject_n_o) run_n++;
            else if (prev_n) begin check("pulse_n_len", run_n, P); run_n = 0; end
            if (done_o || state_o == 3'd6) begin
                if (sbq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_outcome: state %0d with empty scoreboard", state_o);
                end else begin
                    me = sbq.pop_front();
                    check("outcome_is_fault", int'(state_o == 3'd6), me.fault);
                    check("outcome_cycle", cyc, me.dur);
                    check("dime_count", dimes, me.dimes);
                    check("nickel_count", nickels, me.nickels);
                    check("remaining", int'(remaining_o), me.rem);
                    check("fault_flag", int'(fault_o), me.fault);
                end
            end
        end
        prev_s = state_o;
        prev_d = eject_d_o;
        prev_n = eject_n_o;
    end

    task automatic wait_ready();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ready_o) return;
        end
        n_checks++; n_fail++;
        $display("FAIL ready_timeout: ready stayed 0 for 400 cycles");
    endtask

    task automatic run_txn(input int amt, input bit de0, input bit ne0,
                           input bit de1, input bit ne1, input int k);
        sbq.push_back(model(amt, de0, ne0, de1, ne1, k));
        wait_ready();
        amount = AMT_W'(amt);
        dime_empty = de0;
        nickel_empty = ne0;
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        if (k != NO_SW) begin
            repeat (k * COIN_CYC) @(posedge clk);
            #1;
            dime_empty = de1;
            nickel_empty = ne1;
        end
        wait_ready();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, amt, k;
        bit de, ne, de1, ne1;

        // Reset state, before any clock edge.
        #2;
        check("rst_ready", int'(ready_o), 1);
        check("rst_eject", int'(eject_d_o | eject_n_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_fault", int'(fault_o), 0);
        check("rst_remaining", int'(remaining_o), 0);
        check("rst_state", int'(state_o), 0);
        @(negedge clk) rst_n = 1'b1;

        // Reset asserted mid dime pulse drops the solenoid at once.
        wait_ready();
        amount = 4'd3; req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_eject_d", int'(eject_d_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_eject_d", int'(eject_d_o), 0);
        check("async_rst_state", int'(state_o), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", int'(ready_o), 1);
        check("post_rst_state", int'(state_o), 0);
        check("post_rst_remaining", int'(remaining_o), 0);
        @(negedge clk) mon_en = 1'b1;

        // Directed scenarios.
        run_txn(3, 0, 0, 0, 0, NO_SW);          // dime then nickel, Done at 14
        run_txn(4, 1, 0, 1, 0, NO_SW);          // four nickels, Done at 26
        run_txn(2, 1, 0, 1, 1, 1);              // nickel hopper runs dry -> FAULT at 8
        check("fault_sticky", int'(fault_o), 1);
        check("fault_remaining", int'(remaining_o), 1);
        run_txn(1, 0, 0, 0, 0, NO_SW);          // next request clears Fault
        run_txn(1, 0, 1, 0, 1, NO_SW);          // no dime for a single nickel -> FAULT at 2
        run_txn(15, 0, 0, 0, 0, NO_SW);         // largest amount

        // Req held high: one accept per visit to IDLE.
        sbq.push_back(model(0, 0, 0, 0, 0, NO_SW));
        sbq.push_back(model(0, 0, 0, 0, 0, NO_SW));
        wait_ready();
        base = n_acc;
        amount = '0; req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (n_acc >= base + 2) break;
        end
        req = 1'b0;
        wait_ready();
        repeat (4) @(negedge clk);
        check("held_req_accepts", n_acc - base, 2);

        // Random transactions, some with a hopper state change mid-payout.
        for (int t = 0; t < 40; t++) begin
            amt = $urandom_range(0, 15);
            de  = ($urandom_range(0, 3) == 0);
            ne  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                k   = $urandom_range(1, 3);
                de1 = ($urandom_range(0, 1) == 0);
                ne1 = ($urandom_range(0, 1) == 0);
            end else begin
                k = NO_SW; de1 = de; ne1 = ne;
            end
            run_txn(amt, de, ne, de1, ne1, k);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
